// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - serial MCU byte loader that fills the 8-bit test RAM and reports frame completion
module ram_loader #(
  parameter int AW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          sck_i,
  input  logic          sdi_i,
  input  logic          cs_n_i,
  input  logic          rd_busy_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [7:0]    wr_data_o,
  output logic          frame_done_o,
  output logic [AW:0]   byte_cnt_o,
  output logic          ovf_o,
  output logic          rej_o
);

  typedef enum logic [1:0] {IDLE, RECV, IGNORE, DONE} state_t;

  localparam logic [AW:0] DEPTH  = {1'b1, {AW{1'b0}}};
  localparam int          SETTLE = SYNC_STAGES + 1;
  localparam int          SW     = $clog2(SETTLE + 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [SW-1:0]          settle_q, settle_d;
  logic [7:0]             shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   byte_rdy_q, byte_rdy_d;
  logic [AW:0]            addr_q, addr_d;
  logic                   wr_en_q, wr_en_d;
  logic [AW-1:0]          wr_addr_q, wr_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic                   frame_done_q, frame_done_d;
  logic [AW:0]            byte_cnt_q, byte_cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   rej_q, rej_d;

  logic sck_s, cs_s, sdi_s;
  logic settled, sck_rise, cs_rise, cs_fall;

  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign cs_s  = cs_sync_q[SYNC_STAGES-1];
  assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

  // Edges are only trusted once the chains hold real pad samples, so a cs_n
  // still low across a reset cannot masquerade as a new frame start.
  assign settled  = (settle_q == SW'(SETTLE));
  assign sck_rise = settled & sck_s & ~sck_prev_q;
  assign cs_rise  = settled & cs_s & ~cs_prev_q;
  assign cs_fall  = settled & ~cs_s & cs_prev_q;

  always_comb begin
    state_d      = state_q;
    sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], sck_i};
    cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
    sdi_sync_d   = {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
    sck_prev_d   = sck_s;
    cs_prev_d    = cs_s;
    settle_d     = settled ? settle_q : settle_q + SW'(1);
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    byte_rdy_d   = 1'b0;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    byte_cnt_d   = byte_cnt_q;
    ovf_d        = ovf_q;
    rej_d        = 1'b0;

    // Completed byte is committed one cycle after its 8th bit, even if the
    // frame closes in that same cycle.
    if (byte_rdy_q) begin
      if (addr_q == DEPTH) begin
        ovf_d = 1'b1;
      end else begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q[AW-1:0];
        wr_data_d = shift_q;
        addr_d    = addr_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          if (!rd_busy_i) begin
            state_d   = RECV;
            bit_cnt_d = 3'd0;
            addr_d    = '0;
            ovf_d     = 1'b0;
          end else begin
            state_d = IGNORE;
            rej_d   = 1'b1;
          end
        end
      end
      RECV: begin
        if (cs_rise) begin
          state_d   = DONE;
          bit_cnt_d = 3'd0;
        end else if (sck_rise) begin
          shift_d   = {shift_q[6:0], sdi_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_rdy_d = 1'b1;
          end
        end
      end
      IGNORE: begin
        if (cs_rise) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        frame_done_d = 1'b1;
        byte_cnt_d   = addr_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      sck_sync_q   <= '0;
      cs_sync_q    <= '1;
      sdi_sync_q   <= '0;
      sck_prev_q   <= 1'b0;
      cs_prev_q    <= 1'b1;
      settle_q     <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      byte_rdy_q   <= 1'b0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      byte_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      rej_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sck_sync_q   <= sck_sync_d;
      cs_sync_q    <= cs_sync_d;
      sdi_sync_q   <= sdi_sync_d;
      sck_prev_q   <= sck_prev_d;
      cs_prev_q    <= cs_prev_d;
      settle_q     <= settle_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_rdy_q   <= byte_rdy_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      byte_cnt_q   <= byte_cnt_d;
      ovf_q        <= ovf_d;
      rej_q        <= rej_d;
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign frame_done_o = frame_done_q;
  assign byte_cnt_o   = byte_cnt_q;
  assign ovf_o        = ovf_q;
  assign rej_o        = rej_q;

endmodule
